// File: rtl/action_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : action_pkg
//  Description : Shared constants for the action executor: command and strobe
//                bit positions, FSM state encodings and the fixed table of
//                machine locations on the 8x8 grid.
//  Revision    : 1.0 - initial release
// ============================================================================
package action_pkg;

    // control_data bit positions {move, throw, interact, put, get}
    localparam int MOVE_B     = 4;
    localparam int THROW_B    = 3;
    localparam int INTERACT_B = 2;
    localparam int PUT_B      = 1;
    localparam int GET_B      = 0;

    // act_strobe bit positions {throw, interact, put, get}
    localparam int STB_THROW_B    = 3;
    localparam int STB_INTERACT_B = 2;
    localparam int STB_PUT_B      = 1;
    localparam int STB_GET_B      = 0;

    // FSM state encodings
    localparam int         STATE_W = 3;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MOVE    = 3'd1;
    localparam logic [2:0] ARRIVED = 3'd2;
    localparam logic [2:0] ACT     = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    // Machine location table; machine ID n lives at element n.
    // ID1 (0,4), ID2 (7,0), ID3 (5,2), ID4 (7,7). Every other ID is invalid.
    localparam int              MACH_COUNT = 4;
    localparam logic [4:1][2:0] MACH_X     = {3'd7, 3'd5, 3'd7, 3'd0};
    localparam logic [4:1][2:0] MACH_Y     = {3'd7, 3'd2, 3'd0, 3'd4};

endpackage
`default_nettype wire

// File: rtl/machine_map.sv
`default_nettype none
// ============================================================================
//  Module      : machine_map
//  Description : Combinational lookup of a machine ID into its grid location.
//  Ports       : target_machine - machine ID to look up
//                map_x, map_y   - location of the machine (0 when invalid)
//                map_valid      - ID is present in the machine table
//  Revision    : 1.0 - initial release
// ============================================================================
module machine_map
    import action_pkg::*;
#(
    parameter int COORD_W = 3
) (
    input  logic [7:0]         target_machine,
    output logic [COORD_W-1:0] map_x,
    output logic [COORD_W-1:0] map_y,
    output logic               map_valid
);

    always_comb begin
        map_x     = '0;
        map_y     = '0;
        map_valid = 1'b0;
        for (int i = 1; i <= MACH_COUNT; i++) begin
            if (target_machine == 8'(i)) begin
                map_x     = COORD_W'(MACH_X[i]);
                map_y     = COORD_W'(MACH_Y[i]);
                map_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/action_executor.sv
`default_nettype none
// ============================================================================
//  Module      : action_executor
//  Description : Command responder for the action controller. Walks the avatar
//                one cell per STEP_CYCLES toward the selected machine (x first,
//                then y), raises move_ready on arrival and emits exactly one
//                act_strobe pulse per held action command.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                control_data    - one-hot {move, throw, interact, put, get}
//                target_machine  - machine ID for move
//                move_ready      - avatar stands on the latched target
//                pos_x, pos_y    - current avatar position
//                act_strobe      - one-cycle {throw, interact, put, get} pulse
//                busy            - walking, acting or waiting for release
//                err             - one-cycle pulse on multi-hot command or
//                                  unknown machine ID
//  Revision    : 1.0 - initial release
// ============================================================================
module action_executor
    import action_pkg::*;
#(
    parameter int COORD_W     = 3,
    parameter int STEP_CYCLES = 4,
    parameter int HOME_X      = 0,
    parameter int HOME_Y      = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         control_data,
    input  logic [7:0]         target_machine,
    output logic               move_ready,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [3:0]         act_strobe,
    output logic               busy,
    output logic               err
);

    localparam int                 CNT_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
    localparam logic [COORD_W-1:0] C_ONE      = COORD_W'(1);

    logic [STATE_W-1:0] r_state, w_state_nxt;
    logic [COORD_W-1:0] r_pos_x, w_pos_x_nxt;
    logic [COORD_W-1:0] r_pos_y, w_pos_y_nxt;
    logic [COORD_W-1:0] r_tx, w_tx_nxt;
    logic [COORD_W-1:0] r_ty, w_ty_nxt;
    logic [7:0]         r_tid, w_tid_nxt;
    logic               r_tvalid, w_tvalid_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [4:0]         r_code, w_code_nxt;
    logic               w_err_nxt;
    logic [3:0]         w_strobe_nxt;

    logic               r_move_ready;
    logic [3:0]         r_act_strobe;
    logic               r_busy;
    logic               r_err;

    logic [COORD_W-1:0] w_map_x;
    logic [COORD_W-1:0] w_map_y;
    logic               w_map_valid;

    logic w_none;
    logic w_multi;
    logic w_is_action;
    logic w_at_tgt;

    machine_map #(
        .COORD_W (COORD_W)
    ) u_machine_map (
        .target_machine (target_machine),
        .map_x          (w_map_x),
        .map_y          (w_map_y),
        .map_valid      (w_map_valid)
    );

    assign w_none      = (control_data == 5'd0);
    // x & (x-1) clears the lowest set bit; anything left means two or more bits
    assign w_multi     = |(control_data & (control_data - 5'd1));
    assign w_is_action = |control_data[THROW_B:GET_B];
    assign w_at_tgt    = r_tvalid && (r_pos_x == r_tx) && (r_pos_y == r_ty);

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pos_x_nxt  = r_pos_x;
        w_pos_y_nxt  = r_pos_y;
        w_tx_nxt     = r_tx;
        w_ty_nxt     = r_ty;
        w_tid_nxt    = r_tid;
        w_tvalid_nxt = r_tvalid;
        w_cnt_nxt    = r_cnt;
        w_code_nxt   = r_code;
        w_err_nxt    = 1'b0;

        if (w_multi) begin
            // Illegal command: flag it and hold everything; ACT still only
            // lasts a single cycle.
            w_err_nxt = 1'b1;
            if (r_state == ACT) begin
                w_state_nxt = DONE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (control_data[MOVE_B]) begin
                        if (w_map_valid) begin
                            w_tx_nxt     = w_map_x;
                            w_ty_nxt     = w_map_y;
                            w_tid_nxt    = target_machine;
                            w_tvalid_nxt = 1'b1;
                            w_cnt_nxt    = '0;
                            w_state_nxt  = MOVE;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (control_data[THROW_B]) begin
                        w_code_nxt  = control_data;
                        w_state_nxt = ACT;
                    end
                end

                MOVE: begin
                    if (w_none) begin
                        w_state_nxt = IDLE;
                    end else if (control_data[THROW_B]) begin
                        w_code_nxt  = control_data;
                        w_state_nxt = ACT;
                    end else if (w_at_tgt) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ARRIVED;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_pos_x != r_tx) begin
                            w_pos_x_nxt = (r_tx > r_pos_x) ? r_pos_x + C_ONE : r_pos_x - C_ONE;
                        end else begin
                            w_pos_y_nxt = (r_ty > r_pos_y) ? r_pos_y + C_ONE : r_pos_y - C_ONE;
                        end
                        // A changed ID only takes effect at a step boundary;
                        // this step still heads for the old target.
                        if (control_data[MOVE_B] && (target_machine != r_tid)) begin
                            if (w_map_valid) begin
                                w_tx_nxt  = w_map_x;
                                w_ty_nxt  = w_map_y;
                                w_tid_nxt = target_machine;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end

                ARRIVED: begin
                    if (w_none) begin
                        w_state_nxt = IDLE;
                    end else if (control_data[MOVE_B]) begin
                        if (target_machine != r_tid) begin
                            if (w_map_valid) begin
                                w_tx_nxt    = w_map_x;
                                w_ty_nxt    = w_map_y;
                                w_tid_nxt   = target_machine;
                                w_cnt_nxt   = '0;
                                w_state_nxt = MOVE;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                        end
                    end else begin
                        w_code_nxt  = control_data;
                        w_state_nxt = ACT;
                    end
                end

                ACT: begin
                    w_state_nxt = DONE;
                end

                DONE: begin
                    // Hold here while the same code stays applied so a held
                    // command produces only one strobe.
                    if (control_data != r_code) begin
                        if (w_none || control_data[MOVE_B]) begin
                            w_state_nxt = IDLE;
                        end else if (w_is_action && w_at_tgt) begin
                            w_code_nxt  = control_data;
                            w_state_nxt = ACT;
                        end
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_strobe_nxt = '0;
        if (w_state_nxt == ACT) begin
            w_strobe_nxt[STB_THROW_B]    = w_code_nxt[THROW_B];
            w_strobe_nxt[STB_INTERACT_B] = w_code_nxt[INTERACT_B];
            w_strobe_nxt[STB_PUT_B]      = w_code_nxt[PUT_B];
            w_strobe_nxt[STB_GET_B]      = w_code_nxt[GET_B];
        end
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pos_x      <= COORD_W'(HOME_X);
            r_pos_y      <= COORD_W'(HOME_Y);
            r_tx         <= '0;
            r_ty         <= '0;
            r_tid        <= '0;
            r_tvalid     <= 1'b0;
            r_cnt        <= '0;
            r_code       <= '0;
            r_move_ready <= 1'b0;
            r_act_strobe <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos_x      <= w_pos_x_nxt;
            r_pos_y      <= w_pos_y_nxt;
            r_tx         <= w_tx_nxt;
            r_ty         <= w_ty_nxt;
            r_tid        <= w_tid_nxt;
            r_tvalid     <= w_tvalid_nxt;
            r_cnt        <= w_cnt_nxt;
            r_code       <= w_code_nxt;
            r_move_ready <= (w_state_nxt == ARRIVED);
            r_act_strobe <= w_strobe_nxt;
            r_busy       <= (w_state_nxt == MOVE) || (w_state_nxt == ACT) || (w_state_nxt == DONE);
            r_err        <= w_err_nxt;
        end
    end

    assign move_ready = r_move_ready;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign act_strobe = r_act_strobe;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_action_executor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_action_executor
//  Description : Self-checking bench for action_executor. A behavioural model
//                tracks the avatar and command handling cycle by cycle; the
//                directed scenarios add fixed expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_action_executor;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] control_data = 5'd0;
    logic [7:0] target_machine = 8'd0;
    logic       move_ready;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [3:0] act_strobe;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    action_executor #(
        .COORD_W     (3),
        .STEP_CYCLES (STEP),
        .HOME_X      (0),
        .HOME_Y      (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .control_data   (control_data),
        .target_machine (target_machine),
        .move_ready     (move_ready),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .act_strobe     (act_strobe),
        .busy           (busy),
        .err            (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------------
    typedef enum int {MD_IDLE, MD_WALK, MD_READY, MD_FIRE, MD_HOLD} mode_t;

    mode_t      md = MD_IDLE;
    int         mx = 0, my = 0, mtx = 0, mty = 0, mphase = 0;
    logic [7:0] mtid = 0;
    bit         mtvalid = 0;
    logic [4:0] mcode = 0;
    int         e_ready = 0, e_busy = 0, e_err = 0, e_stb = 0;

    function automatic bit lookup(input logic [7:0] id, output int x, output int y);
        x = 0;
        y = 0;
        case (id)
            8'd1: begin x = 0; y = 4; return 1'b1; end
            8'd2: begin x = 7; y = 0; return 1'b1; end
            8'd3: begin x = 5; y = 2; return 1'b1; end
            8'd4: begin x = 7; y = 7; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    task automatic fire(input logic [4:0] cd);
        md    = MD_FIRE;
        mcode = cd;
        e_stb = int'(cd[3:0]);
    endtask

    task automatic model_step(input logic [4:0] cd, input logic [7:0] tm, input logic r);
        int nx, ny;
        bit ok, none_c, move_c, throw_c, at_tgt;
        e_err   = 0;
        e_stb   = 0;
        none_c  = (cd == 5'd0);
        move_c  = (cd == 5'b10000);
        throw_c = (cd == 5'b01000);
        at_tgt  = mtvalid && (mx == mtx) && (my == mty);
        if (r) begin
            md = MD_IDLE; mx = 0; my = 0; mtx = 0; mty = 0;
            mtid = 0; mtvalid = 0; mphase = 0; mcode = 0;
        end else if ($countones(cd) > 1) begin
            e_err = 1;
            if (md == MD_FIRE) md = MD_HOLD;
        end else begin
            case (md)
                MD_IDLE: begin
                    if (move_c) begin
                        ok = lookup(tm, nx, ny);
                        if (ok) begin
                            mtx = nx; mty = ny; mtid = tm; mtvalid = 1; mphase = 0; md = MD_WALK;
                        end else e_err = 1;
                    end else if (throw_c) fire(cd);
                end
                MD_WALK: begin
                    if (none_c) md = MD_IDLE;
                    else if (throw_c) fire(cd);
                    else if (at_tgt) md = MD_READY;
                    else if (mphase == STEP - 1) begin
                        mphase = 0;
                        if (mx != mtx) mx += (mtx > mx) ? 1 : -1;
                        else my += (mty > my) ? 1 : -1;
                        if (move_c && tm != mtid) begin
                            ok = lookup(tm, nx, ny);
                            if (ok) begin mtx = nx; mty = ny; mtid = tm; end
                            else e_err = 1;
                        end
                    end else mphase++;
                end
                MD_READY: begin
                    if (none_c) md = MD_IDLE;
                    else if (move_c) begin
                        if (tm != mtid) begin
                            ok = lookup(tm, nx, ny);
                            if (ok) begin mtx = nx; mty = ny; mtid = tm; mphase = 0; md = MD_WALK; end
                            else e_err = 1;
                        end
                    end else fire(cd);
                end
                MD_FIRE: md = MD_HOLD;
                MD_HOLD: begin
                    if (cd != mcode) begin
                        if (none_c || move_c) md = MD_IDLE;
                        else if (at_tgt) fire(cd);
                    end
                end
                default: md = MD_IDLE;
            endcase
        end
        e_ready = (md == MD_READY) ? 1 : 0;
        e_busy  = (md == MD_WALK || md == MD_FIRE || md == MD_HOLD) ? 1 : 0;
    endtask

    // Apply one cycle of stimulus, advance the model and compare every output.
    task automatic tick(input logic [4:0] cd, input logic [7:0] tm, input logic r);
        control_data   = cd;
        target_machine = tm;
        rst            = r;
        @(posedge clk);
        model_step(cd, tm, r);
        #1;
        check_eq("m_pos_x", 32'(pos_x), 32'(mx));
        check_eq("m_pos_y", 32'(pos_y), 32'(my));
        check_eq("m_ready", 32'(move_ready), 32'(e_ready));
        check_eq("m_busy", 32'(busy), 32'(e_busy));
        check_eq("m_err", 32'(err), 32'(e_err));
        check_eq("m_strobe", 32'(act_strobe), 32'(e_stb));
    endtask

    initial begin
        int steps, nstb, found, len, kind;
        logic [4:0] cd;
        logic [7:0] tm;
        logic [7:0] ids [7];
        ids = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd200};

        // Reset for two cycles
        tick(5'd0, 8'd0, 1'b1);
        tick(5'd0, 8'd0, 1'b1);
        check_eq("rst_pos_x", 32'(pos_x), 0);
        check_eq("rst_pos_y", 32'(pos_y), 0);
        check_eq("rst_ready", 32'(move_ready), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_strobe", 32'(act_strobe), 0);
        check_eq("rst_err", 32'(err), 0);

        // Move to ID3 (5,2): one step every STEP cycles, x first then y
        for (int n = 1; n <= 34; n++) begin
            tick(5'b10000, 8'd3, 1'b0);
            steps = (n - 1) / STEP;
            if (steps > 7) steps = 7;
            check_eq("mv3_pos_x", 32'(pos_x), (steps <= 5) ? steps : 5);
            check_eq("mv3_pos_y", 32'(pos_y), (steps <= 5) ? 0 : steps - 5);
            if (n == 1) check_eq("mv3_busy_entry", 32'(busy), 1);
            if (n == 29) check_eq("mv3_ready_early", 32'(move_ready), 0);
            if (n >= 30) check_eq("mv3_ready", 32'(move_ready), 1);
        end

        // Held get yields exactly one strobe with one-cycle latency
        nstb = 0;
        for (int i = 0; i < 20; i++) begin
            tick(5'b00001, 8'd3, 1'b0);
            if (i == 0) check_eq("get_latency", 32'(act_strobe), 1);
            if (act_strobe != 4'd0) nstb++;
        end
        check_eq("get_strobe_count", nstb, 1);
        check_eq("get_done_busy", 32'(busy), 1);
        check_eq("get_done_ready", 32'(move_ready), 0);
        tick(5'd0, 8'd3, 1'b0);
        check_eq("release_ready", 32'(move_ready), 0);
        check_eq("release_busy", 32'(busy), 0);

        // Unknown machine ID
        tick(5'b10000, 8'd9, 1'b0);
        check_eq("unk_err", 32'(err), 1);
        check_eq("unk_busy", 32'(busy), 0);
        check_eq("unk_pos_x", 32'(pos_x), 5);
        check_eq("unk_pos_y", 32'(pos_y), 2);
        tick(5'd0, 8'd9, 1'b0);
        check_eq("unk_err_pulse", 32'(err), 0);

        // Throw mid-move toward ID4, at (3,0)
        tick(5'd0, 8'd0, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(5'b10000, 8'd4, 1'b0);
            if (pos_x == 3'd3 && pos_y == 3'd0) found = 1;
        end
        check_eq("wait_pos_3_0", found, 1);
        tick(5'b01000, 8'd4, 1'b0);
        check_eq("throw_strobe", 32'(act_strobe), 8);
        for (int i = 0; i < 10; i++) begin
            tick(5'b01000, 8'd4, 1'b0);
            check_eq("throw_frozen_x", 32'(pos_x), 3);
            check_eq("throw_frozen_y", 32'(pos_y), 0);
            check_eq("throw_single", 32'(act_strobe), 0);
        end
        tick(5'd0, 8'd4, 1'b0);
        check_eq("throw_idle_busy", 32'(busy), 0);

        // Multi-hot command
        tick(5'b00011, 8'd0, 1'b0);
        check_eq("multi_err", 32'(err), 1);
        check_eq("multi_strobe", 32'(act_strobe), 0);
        tick(5'd0, 8'd0, 1'b0);
        check_eq("multi_err_pulse", 32'(err), 0);

        // Reset in the middle of a move toward ID2
        tick(5'd0, 8'd0, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(5'b10000, 8'd2, 1'b0);
            if (pos_x == 3'd2 && pos_y == 3'd0) found = 1;
        end
        check_eq("wait_pos_2_0", found, 1);
        tick(5'd0, 8'd2, 1'b1);
        check_eq("midrst_pos_x", 32'(pos_x), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        tick(5'd0, 8'd2, 1'b0);
        check_eq("midrst_idle", 32'(busy), 0);

        // Randomized command episodes against the model
        for (int ep = 0; ep < 160; ep++) begin
            kind = int'($urandom_range(0, 9));
            tm   = ids[$urandom_range(0, 6)];
            case (kind)
                0, 1, 2, 3: cd = 5'b10000;
                4:          cd = 5'b00000;
                5:          cd = 5'b01000;
                6:          cd = 5'b00001;
                7:          cd = 5'b00010;
                8:          cd = 5'b00100;
                default: begin
                    cd = 5'($urandom);
                    if ($countones(cd) < 2) cd = 5'b10001;
                end
            endcase
            if ($urandom_range(0, 29) == 0) tick(5'd0, tm, 1'b1);
            len = int'($urandom_range(1, 40));
            for (int c = 0; c < len; c++) begin
                if (cd == 5'b10000 && $urandom_range(0, 15) == 0) tm = ids[$urandom_range(0, 6)];
                tick(cd, tm, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/action_executor.md
Name: action_executor

Overview:
- Responder for the action controller's command interface.
- Consumes the one-hot control_data {move, throw, interact, put, get} and target_machine, and walks the player avatar across an 8x8 grid toward the selected machine.
- Asserts move_ready on arrival, then issues exactly one action strobe per held command.
- Sits between the action controller and the game-world/display logic.

Parameters:
- COORD_W, 3, width of each grid coordinate.
- STEP_CYCLES, 4, clk cycles per one-cell step; must be >=1.
- HOME_X, 0, x position after reset.
- HOME_Y, 0, y position after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- control_data  in  5  one-hot command {move, throw, interact, put, get}, bit4..bit0.
- target_machine  in  8  machine ID for move, get, put and interact.
- move_ready  out  1  high while in ARRIVED, i.e. the avatar is at the latched target.
- pos_x  out  COORD_W  current avatar x.
- pos_y  out  COORD_W  current avatar y.
- act_strobe  out  4  one-cycle pulse {throw, interact, put, get}.
- busy  out  1  high in MOVE, ACT and DONE.
- err  out  1  one-cycle pulse: illegal (multi-hot) control_data, or unknown machine ID on move.

Behaviour:
- Reset, checked every cycle with priority over everything:
  - state=IDLE, pos=(HOME_X,HOME_Y), move_ready=0, act_strobe=0, busy=0, err=0, step counter=0, latched target cleared.
  - Reset mid-MOVE or mid-ACT discards the operation.
- control_data is sampled every clk; 00000 means no command.
- More than one bit set: err=1 for one cycle, the command is ignored and state is unchanged.
- IDLE:
  - move: look up target_machine via machine_map.
    - valid: latch tx,ty; go to MOVE next cycle with step counter=0.
    - invalid: err pulse; stay in IDLE.
  - throw: go to ACT (no movement needed).
  - get, put or interact in IDLE: ignored, because the target has not been reached.
- MOVE:
  - Each cycle, if pos==(tx,ty), go to ARRIVED next cycle. A zero-distance move therefore arrives one cycle after MOVE entry.
  - Otherwise the step counter increments. At STEP_CYCLES-1 the counter wraps to 0 and the avatar steps one cell.
  - Step order: x toward tx first (+1 or -1), then y toward ty. Never diagonal. Coordinates never wrap.
  - If target_machine changes while move is held, re-look-up at the next step boundary and relatch tx,ty. An invalid new ID raises err and keeps the old target.
  - control_data=00000: abort to IDLE; position is kept.
  - throw: go to ACT (throw); position is frozen.
- ARRIVED:
  - move_ready=1.
  - move held: stay in ARRIVED.
  - get, put, interact or throw: go to ACT.
  - 00000: go to IDLE; move_ready falls the same cycle the state leaves ARRIVED.
  - move with a different target_machine: go back to MOVE.
- ACT:
  - Exactly one cycle. act_strobe has only the matching bit set.
  - The command code is latched as the done-code, then go to DONE.
- DONE:
  - No strobes.
  - Wait until control_data differs from the latched code. This guarantees one strobe per held command even though the controller holds the code indefinitely.
  - Then 00000 goes to IDLE; move goes to IDLE-processing on the following cycle; any other action is handled as from ARRIVED if pos still equals the target, otherwise it is ignored.
- Registers: all outputs are registered. Command-to-strobe latency from ARRIVED is 1 cycle (strobe is visible the cycle after the command is sampled).
- Step counter width: clog2(STEP_CYCLES), minimum 1.

Decomposition:
- Package action_pkg holds:
  - control_data bit indices MOVE_B=4, THROW_B=3, INTERACT_B=2, PUT_B=1, GET_B=0.
  - act_strobe bit indices.
  - State encodings IDLE, MOVE, ARRIVED, ACT, DONE.
  - Machine location table: ID1 (0,4), ID2 (7,0), ID3 (5,2), ID4 (7,7). All other IDs are invalid.
- Sub-module machine_map: combinational; target_machine -> {x, y, valid}, using the package table.

Test Plan:
- Reset: assert rst for 2 cycles -> pos=(0,0), move_ready=0, busy=0, act_strobe=0000, err=0.
- Move to ID3, STEP_CYCLES=4:
  - Stimulus: control_data=10000, target_machine=3 held.
  - Required: MOVE entered cycle+1; 7 steps in order x:1..5 then y:1..2, each spaced 4 cycles.
  - Required: move_ready=1 the cycle after pos becomes (5,2), and stays high while move is held.
- Single strobe: after arrival, hold control_data=00001 for 20 cycles -> act_strobe=0001 for exactly one cycle, then DONE. Drop to 00000 -> IDLE, move_ready=0.
- Unknown ID: control_data=10000, target_machine=9 in IDLE -> err=1 for one cycle, state stays IDLE, pos unchanged.
- Throw mid-move: heading to ID4, apply 01000 when pos=(3,0) -> act_strobe=1000 for one cycle, pos frozen at (3,0), no further steps.
- Multi-hot and mid-move reset:
  - control_data=00011 -> err pulse, no strobe.
  - rst during MOVE at pos=(2,0) -> pos=(0,0) and IDLE on the next cycle.
